// File: rtl/interp_sample_tx.sv
// -----------------------------------------------------------------------------
// interp_sample_tx
//
// Sits after the interpolation filter. Each sample_rdy strobe pushes sample_in
// into a small FIFO. A transmit FSM pops one sample per frame and shifts it
// out MSB first to a serial DAC over CS/SCLK/SDATA. The divider sets the SCLK
// rate. When the filter outpaces the DAC, the FIFO absorbs bursts. Any sample
// that arrives while the FIFO is full is dropped, and a sticky overflow flag
// records the loss.
//
// Ports
//   CLOCK       system clock; all logic runs on its rising edge
//   RESET       synchronous, active-high reset
//   sample_rdy  one-cycle strobe; sample_in is valid this cycle
//   sample_in   interpolated sample (two's complement, sent verbatim)
//   fifo_count  current FIFO occupancy (registered)
//   fifo_full   fifo_count == FIFO_DEPTH (registered)
//   overflow    sticky drop flag; only RESET clears it
//   tx_busy     high in LOAD, SHIFT and GAP
//   dac_cs_n    frame select, active low
//   dac_sclk    serial clock, idle low; the DAC samples on its rising edge
//   dac_sdata   serial data, MSB first; changes only while dac_sclk is low
// -----------------------------------------------------------------------------
module interp_sample_tx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int FRAME_GAP  = 2
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic                          sample_rdy,
    input  logic [DATA_W-1:0]             sample_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow,
    output logic                          tx_busy,
    output logic                          dac_cs_n,
    output logic                          dac_sclk,
    output logic                          dac_sdata
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                sdata_q, sdata_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                full_q, full_d;
    logic                overflow_q, overflow_d;

    logic                pop_s;
    logic                push_s;

    // Transmit FSM next-state logic: pop, serial clock divider and shift register
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                if (count_q != '0) begin
                    pop_s   = 1'b1;
                    sr_d    = mem_q[rd_ptr_q];
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                div_d   = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // A falling toggle ends one bit period. The next bit
                    // is presented while SCLK is low.
                    if (sclk_q) begin
                        sr_d  = {sr_q[DATA_W-2:0], 1'b0};
                        bit_d = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            gap_d   = '0;
                            sclk_d  = 1'b0;
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                sclk_d = 1'b0;
                if (gap_q == GAP_LAST) begin
                    if (count_q != '0) begin
                        pop_s   = 1'b1;
                        sr_d    = mem_q[rd_ptr_q];
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                sclk_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output pins are decoded from the next state so that they are registered
    always_comb begin
        cs_n_d  = 1'b1;
        sdata_d = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        if ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) begin
            cs_n_d  = 1'b0;
            sdata_d = sr_d[DATA_W-1];
        end else begin
            cs_n_d  = 1'b1;
            sdata_d = 1'b0;
        end
    end

    // FIFO bookkeeping. A pop in the same cycle frees a slot, so a write is still accepted when the FIFO is full.
    always_comb begin
        push_s     = sample_rdy && ((count_q != FULL_CNT) || pop_s);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == FULL_CNT);
        overflow_d = overflow_q | (sample_rdy & ~push_s);
    end

    // Sample storage. The occupancy count qualifies the contents, so the storage needs no reset.
    always_ff @(posedge CLOCK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // State, FIFO control and output registers. RESET aborts any frame in progress.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sdata_q    <= 1'b0;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            sdata_q    <= sdata_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign fifo_count = count_q;
    assign fifo_full  = full_q;
    assign overflow   = overflow_q;
    assign tx_busy    = busy_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_sdata  = sdata_q;

endmodule

// File: tb/tb_interp_sample_tx.sv
// -----------------------------------------------------------------------------
// tb_interp_sample_tx
//
// Directed test for interp_sample_tx.
// Instance a uses the default parameters (16-bit samples, 8-entry FIFO,
// CLK_DIV=4, FRAME_GAP=2).
// Instance b uses DATA_W=12, CLK_DIV=1 and FRAME_GAP=1.
// A DAC model captures bits on each SCLK rising edge and records, per frame:
// the data word, the cs_n low length, the bit count, the position of the first
// rising edge, and the cs_n high gap before the frame.
// -----------------------------------------------------------------------------
module tb_interp_sample_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_rdy;
    logic [15:0] a_din;
    logic [3:0]  a_cnt;
    logic        a_full, a_ovf, a_busy, a_cs_n, a_sclk, a_sdata;

    logic        b_rst, b_rdy;
    logic [11:0] b_din;
    logic [3:0]  b_cnt;
    logic        b_full, b_ovf, b_busy, b_cs_n, b_sclk, b_sdata;

    interp_sample_tx u_a (
        .CLOCK(clk), .RESET(a_rst), .sample_rdy(a_rdy), .sample_in(a_din),
        .fifo_count(a_cnt), .fifo_full(a_full), .overflow(a_ovf), .tx_busy(a_busy),
        .dac_cs_n(a_cs_n), .dac_sclk(a_sclk), .dac_sdata(a_sdata)
    );

    interp_sample_tx #(.DATA_W(12), .FIFO_DEPTH(8), .CLK_DIV(1), .FRAME_GAP(1)) u_b (
        .CLOCK(clk), .RESET(b_rst), .sample_rdy(b_rdy), .sample_in(b_din),
        .fifo_count(b_cnt), .fifo_full(b_full), .overflow(b_ovf), .tx_busy(b_busy),
        .dac_cs_n(b_cs_n), .dac_sclk(b_sclk), .dac_sdata(b_sdata)
    );

    logic [1:0] cs_w, sclk_w, sdata_w, busy_w;
    assign cs_w    = {b_cs_n, a_cs_n};
    assign sclk_w  = {b_sclk, a_sclk};
    assign sdata_w = {b_sdata, a_sdata};
    assign busy_w  = {b_busy, a_busy};

    int n_checks = 0;
    int n_errors = 0;

    // DAC model state, per instance
    int          per_exp[2]    = '{8, 2};
    int          fr_n[2]       = '{0, 0};
    logic [15:0] fr_data[2][32];
    int          fr_len[2][32];
    int          fr_bits[2][32];
    int          fr_first[2][32];
    int          fr_gap[2][32];
    logic        in_frame[2]   = '{1'b0, 1'b0};
    logic        prev_sclk[2]  = '{1'b0, 1'b0};
    logic        prev_sdata[2] = '{1'b0, 1'b0};
    int          low_len[2]    = '{0, 0};
    int          high_len[2]   = '{0, 0};
    int          cur_bits[2]   = '{0, 0};
    int          cyc_since[2]  = '{0, 0};
    int          first_rise[2] = '{0, 0};
    logic [15:0] cur_data[2]   = '{16'h0000, 16'h0000};
    int          period_bad[2] = '{0, 0};
    int          unstable[2]   = '{0, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DAC model: samples pins on the falling system-clock edge
    initial begin : dac_model
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (cs_w[k] == 1'b0) begin
                    if (!in_frame[k]) begin
                        in_frame[k]       = 1'b1;
                        fr_gap[k][fr_n[k]] = high_len[k];
                        low_len[k]        = 0;
                        cur_bits[k]       = 0;
                        cur_data[k]       = 16'h0000;
                        cyc_since[k]      = 0;
                        first_rise[k]     = 0;
                    end
                    low_len[k]++;
                    cyc_since[k]++;
                    if (sclk_w[k] && !prev_sclk[k]) begin
                        if (cur_bits[k] == 0) first_rise[k] = low_len[k];
                        else if (cyc_since[k] != per_exp[k]) period_bad[k]++;
                        if (sdata_w[k] != prev_sdata[k]) unstable[k]++;
                        cur_data[k]  = {cur_data[k][14:0], sdata_w[k]};
                        cur_bits[k]++;
                        cyc_since[k] = 0;
                    end
                end else begin
                    if (in_frame[k]) begin
                        fr_data[k][fr_n[k]]  = cur_data[k];
                        fr_len[k][fr_n[k]]   = low_len[k];
                        fr_bits[k][fr_n[k]]  = cur_bits[k];
                        fr_first[k][fr_n[k]] = first_rise[k];
                        if (fr_n[k] < 31) fr_n[k]++;
                        in_frame[k] = 1'b0;
                        high_len[k] = 0;
                    end
                    high_len[k]++;
                end
                prev_sclk[k]  = sclk_w[k];
                prev_sdata[k] = sdata_w[k];
            end
        end
    end

    task automatic wait_idle(input int k, input int budget);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (busy_w[k] == 1'b0) && (cs_w[k] == 1'b1) &&
                   (((k == 0) ? a_cnt : b_cnt) == 4'd0);
        end
        check_eq($sformatf("idle_reached_%0d", k), {31'd0, done}, 32'd1);
    endtask

    task automatic wait_cs_high(input int budget);
        int n;
        n = 0;
        while (a_cs_n == 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("cs_high_reached", {31'd0, a_cs_n}, 32'd1);
    endtask

    // Stops a run that would otherwise hang
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] vec3[3] = '{16'h0001, 16'h8000, 16'hFFFF};
    int base;
    int g;

    // Directed stimulus and checks
    initial begin : stim
        a_rst = 1'b1; a_rdy = 1'b0; a_din = 16'h0000;
        b_rst = 1'b1; b_rdy = 1'b0; b_din = 12'h000;
        repeat (3) @(negedge clk);
        check_eq("rst_count", {28'd0, a_cnt}, 32'd0);
        check_eq("rst_full", {31'd0, a_full}, 32'd0);
        check_eq("rst_ovf", {31'd0, a_ovf}, 32'd0);
        check_eq("rst_busy", {31'd0, a_busy}, 32'd0);
        check_eq("rst_cs_n", {31'd0, a_cs_n}, 32'd1);
        check_eq("rst_sclk", {31'd0, a_sclk}, 32'd0);
        check_eq("rst_sdata", {31'd0, a_sdata}, 32'd0);
        check_eq("rst_b_cs_n", {31'd0, b_cs_n}, 32'd1);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // Single sample A5C3 from IDLE
        base = fr_n[0];
        a_rdy = 1'b1; a_din = 16'hA5C3;
        @(negedge clk);
        a_rdy = 1'b0;
        check_eq("t1_cnt_after_write", {28'd0, a_cnt}, 32'd1);
        check_eq("t1_cs_n_before_pop", {31'd0, a_cs_n}, 32'd1);
        check_eq("t1_busy_before_pop", {31'd0, a_busy}, 32'd0);
        @(negedge clk);
        check_eq("t1_cs_n_at_load", {31'd0, a_cs_n}, 32'd0);
        check_eq("t1_cnt_after_pop", {28'd0, a_cnt}, 32'd0);
        check_eq("t1_busy_at_load", {31'd0, a_busy}, 32'd1);
        check_eq("t1_sdata_msb", {31'd0, a_sdata}, 32'd1);
        wait_cs_high(300);
        g = 0;
        while (a_busy && g < 10) begin
            g++;
            @(negedge clk);
        end
        check_eq("t1_gap_busy_cycles", g, 32'd2);
        check_eq("t1_frame_count", fr_n[0] - base, 32'd1);
        check_eq("t1_data", {16'd0, fr_data[0][base]}, 32'h0000A5C3);
        check_eq("t1_cs_low_len", fr_len[0][base], 32'd129);
        check_eq("t1_bits", fr_bits[0][base], 32'd16);
        check_eq("t1_first_rise", fr_first[0][base], 32'd6);
        check_eq("t1_cnt_end", {28'd0, a_cnt}, 32'd0);

        // Three back-to-back strobes
        base = fr_n[0];
        for (int i = 0; i < 3; i++) begin
            a_rdy = 1'b1; a_din = vec3[i];
            @(negedge clk);
        end
        a_rdy = 1'b0;
        wait_idle(0, 800);
        check_eq("t2_frame_count", fr_n[0] - base, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t2_data_%0d", i), {16'd0, fr_data[0][base+i]}, {16'd0, vec3[i]});
            check_eq($sformatf("t2_len_%0d", i), fr_len[0][base+i], 32'd129);
        end
        check_eq("t2_gap_1", fr_gap[0][base+1], 32'd2);
        check_eq("t2_gap_2", fr_gap[0][base+2], 32'd2);
        check_eq("t2_ovf", {31'd0, a_ovf}, 32'd0);

        // Ten strobes: nine accepted, tenth dropped
        base = fr_n[0];
        for (int i = 0; i < 10; i++) begin
            a_rdy = 1'b1; a_din = 16'h1000 + 16'(i);
            @(negedge clk);
        end
        a_rdy = 1'b0;
        check_eq("t3_full", {31'd0, a_full}, 32'd1);
        check_eq("t3_count", {28'd0, a_cnt}, 32'd8);
        check_eq("t3_ovf", {31'd0, a_ovf}, 32'd1);

        // Write while full, landing on the GAP->LOAD pop edge
        wait_cs_high(300);
        @(negedge clk);
        a_rdy = 1'b1; a_din = 16'hBEEF;
        @(negedge clk);
        a_rdy = 1'b0;
        check_eq("t4_cs_n_load", {31'd0, a_cs_n}, 32'd0);
        check_eq("t4_count", {28'd0, a_cnt}, 32'd8);
        check_eq("t4_full", {31'd0, a_full}, 32'd1);
        check_eq("t4_ovf", {31'd0, a_ovf}, 32'd1);
        wait_idle(0, 2000);
        check_eq("t4_frame_count", fr_n[0] - base, 32'd10);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("t4_data_%0d", i), {16'd0, fr_data[0][base+i]}, 32'h1000 + i);
        end
        check_eq("t4_data_last", {16'd0, fr_data[0][base+9]}, 32'h0000BEEF);
        check_eq("t4_gap_last", fr_gap[0][base+9], 32'd2);
        check_eq("t4_ovf_sticky", {31'd0, a_ovf}, 32'd1);

        // RESET mid-frame after five rising SCLK edges
        base = fr_n[0];
        a_rdy = 1'b1; a_din = 16'h5555;
        @(negedge clk);
        a_din = 16'h7777;
        @(negedge clk);
        a_rdy = 1'b0;
        g = 0;
        while (!(a_cs_n == 1'b0 && cur_bits[0] == 5) && g < 300) begin
            @(negedge clk);
            g++;
        end
        check_eq("t5_five_rises", cur_bits[0], 32'd5);
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        check_eq("t5_cs_n", {31'd0, a_cs_n}, 32'd1);
        check_eq("t5_sclk", {31'd0, a_sclk}, 32'd0);
        check_eq("t5_count", {28'd0, a_cnt}, 32'd0);
        check_eq("t5_ovf", {31'd0, a_ovf}, 32'd0);
        check_eq("t5_busy", {31'd0, a_busy}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("t5_no_resend", {31'd0, a_cs_n}, 32'd1);
        check_eq("t5_abort_bits", fr_bits[0][base], 32'd5);
        check_eq("t5_abort_data", {16'd0, fr_data[0][base]}, 32'h0000000A);
        a_rdy = 1'b1; a_din = 16'h1234;
        @(negedge clk);
        a_rdy = 1'b0;
        wait_idle(0, 400);
        check_eq("t5_frames", fr_n[0] - base, 32'd2);
        check_eq("t5_data", {16'd0, fr_data[0][base+1]}, 32'h00001234);
        check_eq("t5_bits", fr_bits[0][base+1], 32'd16);
        check_eq("t5_first_rise", fr_first[0][base+1], 32'd6);

        // Second parameter set: 12-bit frames, CLK_DIV=1, FRAME_GAP=1
        base = fr_n[1];
        b_rdy = 1'b1; b_din = 12'hABC;
        @(negedge clk);
        b_din = 12'h5A3;
        @(negedge clk);
        b_rdy = 1'b0;
        wait_idle(1, 200);
        check_eq("t6_frames", fr_n[1] - base, 32'd2);
        check_eq("t6_data_0", {16'd0, fr_data[1][base]}, 32'h00000ABC);
        check_eq("t6_data_1", {16'd0, fr_data[1][base+1]}, 32'h000005A3);
        check_eq("t6_len", fr_len[1][base], 32'd25);
        check_eq("t6_bits", fr_bits[1][base], 32'd12);
        check_eq("t6_first_rise", fr_first[1][base], 32'd3);
        check_eq("t6_gap", fr_gap[1][base+1], 32'd1);
        check_eq("t6_ovf", {31'd0, b_ovf}, 32'd0);

        check_eq("a_sclk_period_errs", period_bad[0], 32'd0);
        check_eq("b_sclk_period_errs", period_bad[1], 32'd0);
        check_eq("a_sdata_unstable", unstable[0], 32'd0);
        check_eq("b_sdata_unstable", unstable[1], 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/interp_sample_tx.md
Name: interp_sample_tx

Overview:
- Output-side consumer of the interpolation filter's `sample_rdy`/sample bus.
- Captures each interpolated sample into a small FIFO and transmits it to an external serial DAC.
- Transmission uses a CS/SCLK/SDATA frame, MSB first, paced by a programmable SCLK divider.
- Decouples the filter's burst output timing from the fixed DAC serial rate and flags overflow when the filter outpaces the DAC.

Parameters:
- DATA_W, 16, sample width in bits and serial frame length in SCLK periods.
- FIFO_DEPTH, 8, FIFO entries; must be a power of 2, ≥2.
- CLK_DIV, 4, CLOCK cycles per SCLK half-period; ≥1.
- FRAME_GAP, 2, CLOCK cycles `dac_cs_n` is held high between frames; ≥1.

Ports:
- CLOCK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- sample_rdy  in  1  one-cycle strobe: `sample_in` valid this cycle.
- sample_in  in  DATA_W  interpolated sample, two's complement.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- fifo_full  out  1  high when fifo_count == FIFO_DEPTH.
- overflow  out  1  sticky: a sample was dropped; cleared only by RESET.
- tx_busy  out  1  high in LOAD, SHIFT and GAP states.
- dac_cs_n  out  1  frame select, active low.
- dac_sclk  out  1  serial clock, idle low; DAC samples on rising edge.
- dac_sdata  out  1  serial data, MSB first; changes only while `dac_sclk` is low.

Behaviour:

Reset values:
- RESET high at a rising edge sets: FSM=IDLE, FIFO empty (`fifo_count`=0), `overflow`=0, `tx_busy`=0, `dac_cs_n`=1, `dac_sclk`=0, `dac_sdata`=0.
- Divider and bit counters are cleared.
- RESET mid-frame aborts the frame immediately; the partial frame is discarded and no resend occurs.

FIFO:
- Synchronous, registered pointers that wrap modulo FIFO_DEPTH.
- Write: `sample_rdy`=1 and (count < FIFO_DEPTH, or a pop occurs in the same cycle).
- Pop: occurs only on the FSM's IDLE→LOAD or GAP→LOAD transition edge.
- Simultaneous write and pop: both take effect and the count is unchanged. This includes the full case, where the write is accepted.
- `sample_rdy` while full with no pop: the sample is dropped, the count stays at FIFO_DEPTH, and `overflow` goes high on the next edge.
- `fifo_count` and `fifo_full` are registered.

FSM states:
- IDLE: `dac_cs_n`=1, `dac_sclk`=0.
  - If fifo_count ≠ 0, pop the head into shift register `sr` and go to LOAD.
- LOAD (1 cycle): `dac_cs_n`=0, `dac_sclk`=0, `dac_sdata`=sr[DATA_W-1].
  - Clear the divider and bit counter; go to SHIFT.
- SHIFT: the divider counts 0..CLK_DIV-1.
  - On wrap, `dac_sclk` toggles.
  - On a falling toggle (1→0), `sr` shifts left by one and the bit counter increments.
  - After the DATA_W-th falling toggle, go to GAP.
  - Duration in SHIFT is exactly 2·CLK_DIV·DATA_W cycles.
- GAP: `dac_cs_n`=1, `dac_sclk`=0, `dac_sdata`=0; hold for FRAME_GAP cycles.
  - At the end, if fifo_count ≠ 0, pop and go to LOAD; else go to IDLE.
- Illegal encodings go to IDLE.

Timing:
- Frame period back-to-back: 1 + 2·CLK_DIV·DATA_W + FRAME_GAP = 131 cycles at default parameters.
- Latency: a sample written at edge N into an empty FIFO while in IDLE → count=1 after N. The FSM pops at edge N+1, and `dac_cs_n` is low from edge N+1.
- `dac_sdata` is stable across each rising SCLK edge. The first rising edge occurs CLK_DIV cycles after LOAD ends.
- Arithmetic: no sample modification; bits are transmitted verbatim.

Test Plan:
- Reset, then a single `sample_rdy` with sample_in=16'hA5C3 in IDLE:
  - `dac_cs_n` low for 1+128 cycles.
  - The DAC model captures 16'hA5C3 on 16 rising SCLK edges, each SCLK half-period 4 cycles.
  - `fifo_count` returns to 0; `tx_busy` drops after the 2-cycle gap.
- 3 strobes on consecutive cycles (16'h0001, 16'h8000, 16'hFFFF):
  - Three frames in order, separated by exactly 2 cycles of `dac_cs_n` high.
  - No IDLE between frames; `overflow`=0.
- 10 strobes on consecutive cycles during an active frame:
  - The first 9 are accepted: 1 is popped immediately and 8 fill the FIFO.
  - 10th dropped, `fifo_full`=1, and `overflow` stays 1 through all drained frames until RESET.
- FIFO full, with `sample_rdy` coinciding with the GAP→LOAD pop edge:
  - The write is accepted and `fifo_count` stays at 8.
  - `overflow` is unchanged.
- RESET asserted mid-frame, after 5 SCLK rising edges:
  - Next cycle: `dac_cs_n`=1, `dac_sclk`=0, `fifo_count`=0, `overflow`=0.
  - A later sample 16'h1234 transmits correctly from bit 15.
- Parameter sweep CLK_DIV=1, FRAME_GAP=1, DATA_W=12:
  - Frame length 1+24 cycles plus a 1-cycle gap.
  - Sample 12'hABC is received exactly.
